// File: rtl/punc_control.sv
// PUnC LC3 multi-cycle control unit.
// Sequences fetch/decode/execute and drives every datapath strobe.
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        PC_clr,
    output logic        PC_inc,
    output logic        PC_ld,
    output logic        PC_data_sel,
    output logic        PC_add_sel,
    output logic        IR_ld,
    output logic [1:0]  addr_MEM_sel,
    output logic        w_en_MEM,
    output logic        store_ld,
    output logic [2:0]  r_addr_0_RF,
    output logic [2:0]  r_addr_1_RF,
    output logic [2:0]  w_addr_RF,
    output logic [1:0]  w_RF_sel,
    output logic        w_en_RF,
    output logic        A_sel,
    output logic        B_sel,
    output logic [1:0]  sext_sel,
    output logic [1:0]  ALU_sel,
    output logic        NZP_sel,
    output logic        N_ld,
    output logic        Z_ld,
    output logic        P_ld,
    output logic        halted,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        EXEC2  = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_e     state_q, state_d;
    logic [3:0] op;
    logic [2:0] dr, sr;
    logic       br_take;
    logic       unused_ir;

    assign op        = ir[15:12];
    assign dr        = ir[11:9];
    assign sr        = ir[8:6];
    assign br_take   = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign unused_ir = ^ir[4:3];
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (op == OP_HLT) ? HALT : EXEC;
            EXEC:    state_d = (op == OP_LDI || op == OP_STI) ? EXEC2 : FETCH;
            EXEC2:   state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        PC_clr       = 1'b0;
        PC_inc       = 1'b0;
        PC_ld        = 1'b0;
        PC_data_sel  = 1'b0;
        PC_add_sel   = 1'b0;
        IR_ld        = 1'b0;
        addr_MEM_sel = 2'b00;
        w_en_MEM     = 1'b0;
        store_ld     = 1'b0;
        r_addr_0_RF  = 3'd0;
        r_addr_1_RF  = 3'd0;
        w_addr_RF    = 3'd0;
        w_RF_sel     = 2'b00;
        w_en_RF      = 1'b0;
        A_sel        = 1'b0;
        B_sel        = 1'b0;
        sext_sel     = 2'b00;
        ALU_sel      = 2'b00;
        NZP_sel      = 1'b0;
        N_ld         = 1'b0;
        Z_ld         = 1'b0;
        P_ld         = 1'b0;
        halted       = 1'b0;
        unique case (state_q)
            INIT: PC_clr = 1'b1;
            FETCH: begin
                IR_ld  = 1'b1;
                PC_inc = 1'b1;
            end
            EXEC: begin
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        r_addr_0_RF = sr;
                        A_sel       = 1'b1;
                        if (op != OP_NOT) begin
                            r_addr_1_RF = ir[2:0];
                            B_sel       = ir[5];
                        end
                        ALU_sel   = (op == OP_ADD) ? 2'b00 :
                                    (op == OP_AND) ? 2'b01 : 2'b11;
                        w_RF_sel  = 2'b10;
                        w_addr_RF = dr;
                        w_en_RF   = 1'b1;
                        {N_ld, Z_ld, P_ld} = 3'b111;
                    end
                    OP_BR: begin
                        if (br_take) begin
                            PC_add_sel = 1'b1;
                            PC_ld      = 1'b1;
                        end
                    end
                    OP_JMP: begin
                        r_addr_0_RF = sr;
                        A_sel       = 1'b1;
                        ALU_sel     = 2'b10;
                        PC_data_sel = 1'b1;
                        PC_ld       = 1'b1;
                    end
                    OP_JSR: begin
                        // R7 is read as the base before the link write lands
                        w_addr_RF = 3'd7;
                        w_en_RF   = 1'b1;
                        PC_ld     = 1'b1;
                        if (!ir[11]) begin
                            r_addr_0_RF = sr;
                            A_sel       = 1'b1;
                            ALU_sel     = 2'b10;
                            PC_data_sel = 1'b1;
                        end
                    end
                    OP_LD, OP_LDR, OP_ST, OP_STR: begin
                        B_sel        = 1'b1;
                        addr_MEM_sel = 2'b01;
                        if (op[2]) begin
                            A_sel       = 1'b1;
                            r_addr_0_RF = sr;
                            sext_sel    = 2'b01;
                        end else begin
                            sext_sel = 2'b10;
                        end
                        if (!op[0]) begin
                            w_RF_sel  = 2'b01;
                            w_addr_RF = dr;
                            w_en_RF   = 1'b1;
                            NZP_sel   = 1'b1;
                            {N_ld, Z_ld, P_ld} = 3'b111;
                        end else begin
                            r_addr_1_RF = dr;
                            w_en_MEM    = 1'b1;
                        end
                    end
                    OP_LEA: begin
                        B_sel     = 1'b1;
                        sext_sel  = 2'b10;
                        w_RF_sel  = 2'b10;
                        w_addr_RF = dr;
                        w_en_RF   = 1'b1;
                        {N_ld, Z_ld, P_ld} = 3'b111;
                    end
                    OP_LDI, OP_STI: begin
                        B_sel        = 1'b1;
                        sext_sel     = 2'b10;
                        addr_MEM_sel = 2'b01;
                        store_ld     = 1'b1;
                    end
                    default: ;
                endcase
            end
            EXEC2: begin
                addr_MEM_sel = 2'b10;
                if (op == OP_LDI) begin
                    w_RF_sel  = 2'b01;
                    w_addr_RF = dr;
                    w_en_RF   = 1'b1;
                    NZP_sel   = 1'b1;
                    {N_ld, Z_ld, P_ld} = 3'b111;
                end else begin
                    r_addr_1_RF = dr;
                    w_en_MEM    = 1'b1;
                end
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: directed plan cases, random instruction
// stream against an instruction-level reference, reset and halt checks.
module tb_punc_control;

    typedef struct packed {
        logic       pc_clr, pc_inc, pc_ld, pc_dsel, pc_asel, ir_ld;
        logic [1:0] amem;
        logic       wmem, st_ld;
        logic [2:0] r0, r1, wa;
        logic [1:0] wsel;
        logic       wrf, a_sel, b_sel;
        logic [1:0] sext, alu;
        logic       nzp_sel, nl, zl, pl, halt;
    } ctl_t;

    localparam int PH_INIT = 0, PH_FETCH = 1, PH_DEC = 2;
    localparam int PH_EXEC = 3, PH_EXEC2 = 4, PH_HALT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] ir = 16'h0;
    logic n = 1'b0, z = 1'b0, p = 1'b0;
    logic PC_clr, PC_inc, PC_ld, PC_data_sel, PC_add_sel, IR_ld;
    logic [1:0] addr_MEM_sel, w_RF_sel, sext_sel, ALU_sel;
    logic w_en_MEM, store_ld, w_en_RF, A_sel, B_sel, NZP_sel;
    logic [2:0] r_addr_0_RF, r_addr_1_RF, w_addr_RF, state_dbg;
    logic N_ld, Z_ld, P_ld, halted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .PC_clr(PC_clr), .PC_inc(PC_inc), .PC_ld(PC_ld),
        .PC_data_sel(PC_data_sel), .PC_add_sel(PC_add_sel),
        .IR_ld(IR_ld), .addr_MEM_sel(addr_MEM_sel),
        .w_en_MEM(w_en_MEM), .store_ld(store_ld),
        .r_addr_0_RF(r_addr_0_RF), .r_addr_1_RF(r_addr_1_RF),
        .w_addr_RF(w_addr_RF), .w_RF_sel(w_RF_sel), .w_en_RF(w_en_RF),
        .A_sel(A_sel), .B_sel(B_sel), .sext_sel(sext_sel),
        .ALU_sel(ALU_sel), .NZP_sel(NZP_sel),
        .N_ld(N_ld), .Z_ld(Z_ld), .P_ld(P_ld),
        .halted(halted), .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t c;
        c = '{PC_clr, PC_inc, PC_ld, PC_data_sel, PC_add_sel, IR_ld,
              addr_MEM_sel, w_en_MEM, store_ld,
              r_addr_0_RF, r_addr_1_RF, w_addr_RF,
              w_RF_sel, w_en_RF, A_sel, B_sel, sext_sel, ALU_sel,
              NZP_sel, N_ld, Z_ld, P_ld, halted};
        return c;
    endfunction

    // Instruction-level reference: what each LC3 op needs from the datapath
    function automatic ctl_t ref_ctl(input int ph, input logic [15:0] i,
                                     input logic [2:0] f);
        ctl_t c;
        string mn;
        logic [2:0] dr, sr;
        c  = '0;
        dr = i[11:9];
        sr = i[8:6];
        case (i[15:12])
            4'h0: mn = "BR";  4'h1: mn = "ADD"; 4'h2: mn = "LD";
            4'h3: mn = "ST";  4'h4: mn = "JSR"; 4'h5: mn = "AND";
            4'h6: mn = "LDR"; 4'h7: mn = "STR"; 4'h9: mn = "NOT";
            4'hA: mn = "LDI"; 4'hB: mn = "STI"; 4'hC: mn = "JMP";
            4'hE: mn = "LEA"; default: mn = "NOP";
        endcase
        if (ph == PH_INIT) c.pc_clr = 1;
        if (ph == PH_FETCH) begin c.ir_ld = 1; c.pc_inc = 1; end
        if (ph == PH_HALT) c.halt = 1;
        if (ph == PH_EXEC) begin
            if (mn == "ADD" || mn == "AND" || mn == "NOT") begin
                c.r0 = sr; c.a_sel = 1;
                if (mn != "NOT") begin c.r1 = i[2:0]; c.b_sel = i[5]; end
                c.alu = (mn == "ADD") ? 2'd0 : (mn == "AND") ? 2'd1 : 2'd3;
                c.wsel = 2; c.wa = dr; c.wrf = 1;
                {c.nl, c.zl, c.pl} = 3'b111;
            end
            if (mn == "BR" && (i[11:9] & f) != 3'b000) begin
                c.pc_asel = 1; c.pc_ld = 1;
            end
            if (mn == "JMP" || (mn == "JSR" && !i[11])) begin
                c.r0 = sr; c.a_sel = 1; c.alu = 2; c.pc_dsel = 1; c.pc_ld = 1;
            end
            if (mn == "JSR") begin c.wa = 7; c.wrf = 1; c.pc_ld = 1; end
            if (mn == "LD" || mn == "ST" || mn == "LEA" ||
                mn == "LDI" || mn == "STI") begin
                c.b_sel = 1; c.sext = 2;
            end
            if (mn == "LDR" || mn == "STR") begin
                c.b_sel = 1; c.sext = 1; c.a_sel = 1; c.r0 = sr;
            end
            if (mn == "LD" || mn == "LDR" || mn == "ST" || mn == "STR" ||
                mn == "LDI" || mn == "STI") c.amem = 1;
            if (mn == "LD" || mn == "LDR") begin
                c.wsel = 1; c.wa = dr; c.wrf = 1; c.nzp_sel = 1;
                {c.nl, c.zl, c.pl} = 3'b111;
            end
            if (mn == "ST" || mn == "STR") begin c.r1 = dr; c.wmem = 1; end
            if (mn == "LEA") begin
                c.wsel = 2; c.wa = dr; c.wrf = 1;
                {c.nl, c.zl, c.pl} = 3'b111;
            end
            if (mn == "LDI" || mn == "STI") c.st_ld = 1;
        end
        if (ph == PH_EXEC2) begin
            c.amem = 2;
            if (mn == "LDI") begin
                c.wsel = 1; c.wa = dr; c.wrf = 1; c.nzp_sel = 1;
                {c.nl, c.zl, c.pl} = 3'b111;
            end else begin
                c.r1 = dr; c.wmem = 1;
            end
        end
        return c;
    endfunction

    task automatic chk_ph(input string tag, input int ph,
                          input logic [15:0] i, input logic [2:0] f);
        chk({tag, "_state"}, 64'(state_dbg), 64'(ph));
        chk({tag, "_ctl"}, 64'(obs()), 64'(ref_ctl(ph, i, f)));
        chk({tag, "_pc_excl"},
            64'((PC_ld + PC_inc + PC_clr) > 1), 64'(0));
    endtask

    // Release reset just after an edge so INIT lasts one full cycle.
    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_ph("init", PH_INIT, ir, {n, z, p});
        @(negedge clk);
    endtask

    // Entered at a negedge in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input logic [15:0] i, input logic [2:0] f);
        chk_ph("fetch", PH_FETCH, ir, {n, z, p});
        ir = i;
        {n, z, p} = f;
        @(negedge clk);
        chk_ph("decode", PH_DEC, i, f);
        @(negedge clk);
        if (i[15:12] == 4'hF) begin
            chk_ph("halt", PH_HALT, i, f);
            return;
        end
        chk_ph("exec", PH_EXEC, i, f);
        if (i[15:12] == 4'hA || i[15:12] == 4'hB) begin
            @(negedge clk);
            chk_ph("exec2", PH_EXEC2, i, f);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ri;
        #1 rst = 1'b0;
        #1 chk_ph("rst_async", PH_INIT, ir, {n, z, p});
        repeat (3) @(negedge clk);
        chk_ph("rst_hold", PH_INIT, ir, {n, z, p});
        release_rst();

        run_instr(16'h1262, 3'b000);
        chk("add_b_sel", 64'(B_sel), 64'(0));
        run_instr(16'h0405, 3'b010);
        run_instr(16'h0405, 3'b100);
        run_instr(16'hA203, 3'b001);
        run_instr(16'hB5C1, 3'b001);
        run_instr(16'h4802, 3'b000);
        run_instr(16'h4180, 3'b000);
        run_instr(16'hC1C0, 3'b000);

        // reset landing in the middle of an EXEC cycle
        chk_ph("fetch", PH_FETCH, ir, {n, z, p});
        ir = 16'h1262;
        @(negedge clk);
        @(negedge clk);
        chk_ph("mid_exec", PH_EXEC, ir, 3'b000);
        #2 rst = 1'b0;
        #1 chk_ph("mid_abort", PH_INIT, ir, 3'b000);
        release_rst();

        for (int k = 0; k < 200; k++) begin
            ri = 16'($urandom);
            if (ri[15:12] == 4'hF) ri[15:12] = 4'h1;
            run_instr(ri, 3'($urandom_range(0, 7)));
        end

        run_instr(16'hF025, 3'b000);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk_ph("halt_hold", PH_HALT, ir, 3'b000);
        end
        #2 rst = 1'b0;
        #1 chk_ph("halt_rst", PH_INIT, ir, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
